// File: rtl/seg_code_decoder.sv
// rtl/seg_code_decoder.sv - recovers the single input line behind an 8-bit segment code by scanning mask columns
// Optional SEG_DEC_EARLY_EXIT_EN: leave the scan on the first matching column (out_ambig tied 0).
module seg_code_decoder #(
  parameter logic [63:0] MASK   = 64'h00BE_B8A2_B6FD_CFF6,
  parameter int          SCAN_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        code_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SCAN_W-1:0] out_index,
  output logic              out_none,
  output logic              out_err,
  output logic              out_ambig
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [SCAN_W-1:0] IDX_LAST = {SCAN_W{1'b1}};

  logic [1:0]        state_q, state_d;
  logic [SCAN_W-1:0] idx_q, idx_d;
  logic [7:0]        code_q, code_d;
  logic [SCAN_W-1:0] hit_idx_q, hit_idx_d;
  logic              found_q, found_d;
  logic              ambig_q, ambig_d;
  logic [SCAN_W-1:0] res_index_q, res_index_d;
  logic              res_none_q, res_none_d;
  logic              res_err_q, res_err_d;
  logic              res_ambig_q, res_ambig_d;
  logic              hit;
  logic              finish;

  // Column i of MASK is the code word that input line i produces on its own.
  function automatic logic [7:0] col_sig(input logic [SCAN_W-1:0] col);
    logic [7:0] s;
    for (int j = 0; j < 8; j++) begin
      s[j] = MASK[6'(8 * j + int'(col))];
    end
    return s;
  endfunction

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    code_d      = code_q;
    hit_idx_d   = hit_idx_q;
    found_d     = found_q;
    ambig_d     = ambig_q;
    res_index_d = res_index_q;
    res_none_d  = res_none_q;
    res_err_d   = res_err_q;
    res_ambig_d = res_ambig_q;
    hit         = (code_q == col_sig(idx_q));
    finish      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          code_d    = code_in;
          idx_d     = '0;
          hit_idx_d = '0;
          found_d   = 1'b0;
          ambig_d   = 1'b0;
          if (code_in == 8'h00) begin
            state_d     = ST_DONE;
            res_none_d  = 1'b1;
            res_index_d = '0;
            res_err_d   = 1'b0;
            res_ambig_d = 1'b0;
          end else begin
            state_d = ST_SCAN;
          end
        end
      end
      ST_SCAN: begin
        idx_d = idx_q + 1'b1;
        if (hit) begin
          if (!found_q) begin
            found_d   = 1'b1;
            hit_idx_d = idx_q;
          end else begin
            ambig_d = 1'b1;
          end
        end
`ifdef SEG_DEC_EARLY_EXIT_EN
        finish = hit || (idx_q == IDX_LAST);
`else
        finish = (idx_q == IDX_LAST);
`endif
        if (finish) begin
          state_d     = ST_DONE;
          res_none_d  = 1'b0;
          res_index_d = found_d ? hit_idx_d : '0;
          res_err_d   = !found_d;
`ifdef SEG_DEC_EARLY_EXIT_EN
          res_ambig_d = 1'b0;
`else
          res_ambig_d = ambig_d;
`endif
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          res_index_d = '0;
          res_none_d  = 1'b0;
          res_err_d   = 1'b0;
          res_ambig_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      code_q      <= '0;
      hit_idx_q   <= '0;
      found_q     <= 1'b0;
      ambig_q     <= 1'b0;
      res_index_q <= '0;
      res_none_q  <= 1'b0;
      res_err_q   <= 1'b0;
      res_ambig_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      code_q      <= code_d;
      hit_idx_q   <= hit_idx_d;
      found_q     <= found_d;
      ambig_q     <= ambig_d;
      res_index_q <= res_index_d;
      res_none_q  <= res_none_d;
      res_err_q   <= res_err_d;
      res_ambig_q <= res_ambig_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_index = res_index_q;
  assign out_none  = res_none_q;
  assign out_err   = res_err_q;
  assign out_ambig = res_ambig_q;

endmodule

// File: tb/tb_seg_code_decoder.sv
// tb/tb_seg_code_decoder.sv - directed checks of seg_code_decoder with default and ambiguous masks
// Expectations follow SEG_DEC_EARLY_EXIT_EN when it is defined for the build.
module tb_seg_code_decoder;

`ifdef SEG_DEC_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  // Columns listed as {c7..c0}; b differs from default only in column 5 (= column 2 = 4F).
  localparam logic [63:0] COLS_B = 64'h7F07_4F6D_664F_5B06;

  function automatic logic [63:0] transpose(input logic [63:0] cols);
    logic [63:0] m;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        m[8 * j + i] = cols[8 * i + j];
    return m;
  endfunction

  localparam logic [63:0] MASK_B = transpose(COLS_B);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] code_in = 8'h00;
  logic       out_ready = 1'b0;
  logic       in_ready_a, out_valid_a, out_none_a, out_err_a, out_ambig_a;
  logic       in_ready_b, out_valid_b, out_none_b, out_err_b, out_ambig_b;
  logic [2:0] out_index_a, out_index_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seg_code_decoder dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .code_in(code_in),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_index(out_index_a),
    .out_none(out_none_a), .out_err(out_err_a), .out_ambig(out_ambig_a)
  );

  seg_code_decoder #(.MASK(MASK_B)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .code_in(code_in),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_index(out_index_b),
    .out_none(out_none_b), .out_err(out_err_b), .out_ambig(out_ambig_b)
  );

  typedef struct {
    logic [7:0] code;
    int         a_idx; bit a_none; bit a_err; bit a_amb;
    int         b_idx; bit b_none; bit b_err; bit b_amb;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input bit none, input bit err, input int idx);
    if (none) return 1;
    if (err) return 9;
    return EARLY ? idx + 2 : 9;
  endfunction

  // Latency = posedges after the accept edge up to the first edge that sees out_valid high.
  task automatic send_word(input logic [7:0] code, output int lat_a, output int lat_b);
    @(negedge clk);
    chk("accept_in_ready", int'(in_ready_a), 1);
    in_valid = 1'b1;
    code_in  = code;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat_a = 0;
    lat_b = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (out_valid_a && lat_a == 0) lat_a = k;
      if (out_valid_b && lat_b == 0) lat_b = k;
      if (lat_a != 0 && lat_b != 0) break;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("post_hs_out_valid", int'(out_valid_a), 0);
    chk("post_hs_in_ready", int'(in_ready_a), 1);
  endtask

  vec_t vecs[10];

  initial begin
    int la, lb;
    bool_guard: begin end

    vecs[0] = '{8'h5B, 1, 0, 0, 0, 1, 0, 0, 0};
    vecs[1] = '{8'h7F, 7, 0, 0, 0, 7, 0, 0, 0};
    vecs[2] = '{8'h00, 0, 1, 0, 0, 0, 1, 0, 0};
    vecs[3] = '{8'h3F, 0, 0, 1, 0, 0, 0, 1, 0};
    vecs[4] = '{8'h06, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[5] = '{8'h4F, 2, 0, 0, 0, 2, 0, 0, 1};
    vecs[6] = '{8'h7D, 5, 0, 0, 0, 0, 0, 1, 0};
    vecs[7] = '{8'h66, 3, 0, 0, 0, 3, 0, 0, 0};
    vecs[8] = '{8'h86, 0, 0, 1, 0, 0, 0, 1, 0};
    vecs[9] = '{8'h07, 6, 0, 0, 0, 6, 0, 0, 0};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready_a), 1);
    chk("rst_out_valid", int'(out_valid_a), 0);
    chk("rst_out_index", int'(out_index_a), 0);
    chk("rst_out_none", int'(out_none_a), 0);
    chk("rst_out_err", int'(out_err_a), 0);
    chk("rst_out_ambig", int'(out_ambig_a), 0);

    // Backpressure: result must hold while out_ready stays low.
    send_word(8'h5B, la, lb);
    chk("bp_latency", la, exp_lat(0, 0, 1));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_out_valid", int'(out_valid_a), 1);
      chk("bp_out_index", int'(out_index_a), 1);
      chk("bp_in_ready", int'(in_ready_a), 0);
    end
    handshake();

    // Reset mid-scan drops the word.
    @(negedge clk);
    in_valid = 1'b1;
    code_in  = 8'h7F;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midscan_rst_in_ready", int'(in_ready_a), 1);
    la = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid_a) la = 1;
    end
    chk("midscan_rst_no_valid", la, 0);

    foreach (vecs[v]) begin
      send_word(vecs[v].code, la, lb);
      chk($sformatf("v%0d_a_latency", v), la, exp_lat(vecs[v].a_none, vecs[v].a_err, vecs[v].a_idx));
      chk($sformatf("v%0d_b_latency", v), lb, exp_lat(vecs[v].b_none, vecs[v].b_err, vecs[v].b_idx));
      chk($sformatf("v%0d_a_index", v), int'(out_index_a), vecs[v].a_idx);
      chk($sformatf("v%0d_a_none", v), int'(out_none_a), int'(vecs[v].a_none));
      chk($sformatf("v%0d_a_err", v), int'(out_err_a), int'(vecs[v].a_err));
      chk($sformatf("v%0d_a_ambig", v), int'(out_ambig_a), EARLY ? 0 : int'(vecs[v].a_amb));
      chk($sformatf("v%0d_b_index", v), int'(out_index_b), vecs[v].b_idx);
      chk($sformatf("v%0d_b_none", v), int'(out_none_b), int'(vecs[v].b_none));
      chk($sformatf("v%0d_b_err", v), int'(out_err_b), int'(vecs[v].b_err));
      chk($sformatf("v%0d_b_ambig", v), int'(out_ambig_b), EARLY ? 0 : int'(vecs[v].b_amb));
      handshake();
      chk($sformatf("v%0d_b_in_ready", v), int'(in_ready_b), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
